// File: rtl/d8m_pattern_tx_pkg.sv
// d8m_tx_pkg: shared types and constants for the D8M synthetic pattern source.
//   - state_e   : timing FSM states
//   - mode_e    : pattern selector encodings
//   - bayer_e   : Bayer site colour, encoded as the bit index into a bar's {R,G,B}
//   - BAR_ROM   : {R,G,B} components of the eight colour bars
//   - bayer_site: GRBG site lookup from the LSBs of x and y
package d8m_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_VBLANK      = 2'd1,
    S_LINE_BLANK  = 2'd2,
    S_LINE_ACTIVE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_FLAT  = 2'd3
  } mode_e;

  // Values chosen so a site indexes its component directly in a {R,G,B} triple.
  typedef enum logic [1:0] {
    BAYER_B = 2'd0,
    BAYER_G = 2'd1,
    BAYER_R = 2'd2
  } bayer_e;

  localparam int unsigned COORD_W = 12;
  localparam logic [9:0]  PIX_MAX = 10'd1023;
  localparam logic [9:0]  PIX_MIN = 10'd0;

  // Index 0 = white ... index 7 = black; each entry is {R,G,B}.
  localparam logic [7:0][2:0] BAR_ROM = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  // GRBG: even rows G R G R ..., odd rows B G B G ...
  function automatic bayer_e bayer_site(input logic x0, input logic y0);
    bayer_e site;
    case ({y0, x0})
      2'b00:   site = BAYER_G;
      2'b01:   site = BAYER_R;
      2'b10:   site = BAYER_B;
      2'b11:   site = BAYER_G;
      default: site = BAYER_G;
    endcase
    return site;
  endfunction

endpackage

// File: rtl/d8m_pattern_tx_if.sv
// d8m_pattern_tx_if: control inputs and pixel-bus outputs of the pattern source.
//   iEN, iMODE, iLEVEL         : frame enable, pattern select, flat level
//   oPIXEL_VS/HS/D             : frame valid, line valid, 10-bit raw Bayer pixel
//   oFRAME_CNT, oBUSY          : completed-frame count, generator active
// master = the pattern source, slave = whoever controls and consumes it.
interface d8m_pattern_tx_if;
  logic        iEN;
  logic [1:0]  iMODE;
  logic [9:0]  iLEVEL;
  logic        oPIXEL_VS;
  logic        oPIXEL_HS;
  logic [9:0]  oPIXEL_D;
  logic [15:0] oFRAME_CNT;
  logic        oBUSY;

  modport master (
    input  iEN, iMODE, iLEVEL,
    output oPIXEL_VS, oPIXEL_HS, oPIXEL_D, oFRAME_CNT, oBUSY
  );

  modport slave (
    output iEN, iMODE, iLEVEL,
    input  oPIXEL_VS, oPIXEL_HS, oPIXEL_D, oFRAME_CNT, oBUSY
  );
endinterface

// File: rtl/d8m_pattern_tx_gen.sv
// d8m_pattern_gen: maps pixel coordinates and latched pattern settings to a
// raw Bayer value, with one register stage.
//   iCLK, iRST  : pixel clock, async active-high reset
//   valid_i     : coordinate is an active pixel in the next cycle
//   x_i         : column (low 10 bits)
//   y_lsb_i     : row bit 0 (Bayer row parity)
//   y_chk_i     : row bit CHECK_LOG2 (checkerboard row band)
//   bar_i       : colour bar index 0..7
//   mode_i      : pattern select
//   level_i     : flat-mode value
//   pix_o       : registered pixel, 0 whenever valid_i was low
// The caller presents next-cycle coordinates so pix_o lines up with its
// registered line-valid.
module d8m_pattern_gen
  import d8m_tx_pkg::*;
#(
  parameter int CHECK_LOG2 = 5
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       valid_i,
  input  logic [9:0] x_i,
  input  logic       y_lsb_i,
  input  logic       y_chk_i,
  input  logic [2:0] bar_i,
  input  logic [1:0] mode_i,
  input  logic [9:0] level_i,
  output logic [9:0] pix_o
);

  logic [9:0] pix_d;
  logic [9:0] pix_q;
  bayer_e     site_s;
  logic [2:0] bar_rgb_s;

  assign site_s    = bayer_site(x_i[0], y_lsb_i);
  assign bar_rgb_s = BAR_ROM[bar_i];

  // Pattern selection for the coming pixel; blanking forces 0.
  always_comb begin
    pix_d = PIX_MIN;
    if (valid_i) begin
      case (mode_i)
        MODE_BARS:  pix_d = bar_rgb_s[site_s] ? PIX_MAX : PIX_MIN;
        MODE_RAMP:  pix_d = x_i;
        MODE_CHECK: pix_d = (x_i[CHECK_LOG2] ^ y_chk_i) ? PIX_MAX : PIX_MIN;
        MODE_FLAT:  pix_d = level_i;
        default:    pix_d = PIX_MIN;
      endcase
    end else begin
      pix_d = PIX_MIN;
    end
  end

  // Output register stage.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pix_q <= 10'd0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/d8m_pattern_tx.sv
// d8m_pattern_tx: synthetic D8M parallel pixel source (frame valid, line
// valid, 10-bit GRBG raw Bayer) with selectable test patterns.
//   iCLK  : pixel clock
//   iRST  : async active-high reset
//   bus   : d8m_pattern_tx_if.master (iEN/iMODE/iLEVEL in,
//           oPIXEL_VS/HS/D, oFRAME_CNT, oBUSY out)
// Frame: V_BLANK_CLKS clocks VS low, then V_ACTIVE lines of H_BLANK clocks
// HS low followed by H_ACTIVE clocks HS high. Mode and level are latched on
// the last VS-low clock so a frame never mixes patterns.
module d8m_pattern_tx
  import d8m_tx_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int H_BLANK      = 160,
  parameter int V_ACTIVE     = 480,
  parameter int V_BLANK_CLKS = 8000,
  parameter int CHECK_LOG2   = 5
) (
  input  logic            iCLK,
  input  logic            iRST,
  d8m_pattern_tx_if.master bus
);

  localparam int TMR_MAX  = (V_BLANK_CLKS > H_BLANK) ? V_BLANK_CLKS : H_BLANK;
  localparam int TW       = $clog2(TMR_MAX + 1);
  localparam int BAR_STEP = H_ACTIVE / 8;
  localparam int SUB_W    = $clog2(BAR_STEP) + 1;

  localparam logic [TW-1:0]      VB_LAST  = TW'(V_BLANK_CLKS - 1);
  localparam logic [TW-1:0]      HB_LAST  = TW'(H_BLANK - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(BAR_STEP - 1);

  logic [1:0]         state_q,     state_d;
  logic [TW-1:0]      tmr_q,       tmr_d;
  logic [COORD_W-1:0] hcnt_q,      hcnt_d;
  logic [COORD_W-1:0] vcnt_q,      vcnt_d;
  logic [2:0]         bar_q,       bar_d;
  logic [SUB_W-1:0]   sub_q,       sub_d;
  logic [1:0]         mode_q,      mode_d;
  logic [9:0]         level_q,     level_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               vs_q,        vs_d;
  logic               hs_q,        hs_d;
  logic               busy_q,      busy_d;
  logic [9:0]         pix_s;

  // Timing FSM, counters and pattern latch.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    bar_d       = bar_q;
    sub_d       = sub_q;
    mode_d      = mode_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iEN) begin
          state_d = S_VBLANK;
          tmr_d   = {TW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VBLANK: begin
        if (tmr_q == VB_LAST) begin
          state_d = S_LINE_BLANK;
          tmr_d   = {TW{1'b0}};
          vcnt_d  = {COORD_W{1'b0}};
          mode_d  = bus.iMODE;
          level_d = bus.iLEVEL;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_LINE_BLANK: begin
        if (tmr_q == HB_LAST) begin
          state_d = S_LINE_ACTIVE;
          tmr_d   = {TW{1'b0}};
          hcnt_d  = {COORD_W{1'b0}};
          bar_d   = 3'd0;
          sub_d   = {SUB_W{1'b0}};
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_LINE_ACTIVE: begin
        if (hcnt_q == H_LAST) begin
          tmr_d = {TW{1'b0}};
          if (vcnt_q != V_LAST) begin
            vcnt_d  = vcnt_q + 1'b1;
            state_d = S_LINE_BLANK;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            // iEN only matters here and in idle, so frames are never cut short.
            state_d     = bus.iEN ? S_VBLANK : S_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
          // Bar index = x*8/H_ACTIVE, done as a counter stepping every H_ACTIVE/8.
          if (sub_q == SUB_LAST) begin
            sub_d = {SUB_W{1'b0}};
            bar_d = bar_q + 3'd1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags decoded from the next state so they register with the state.
  always_comb begin
    vs_d   = (state_d == S_LINE_BLANK) || (state_d == S_LINE_ACTIVE);
    hs_d   = (state_d == S_LINE_ACTIVE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      tmr_q       <= {TW{1'b0}};
      hcnt_q      <= {COORD_W{1'b0}};
      vcnt_q      <= {COORD_W{1'b0}};
      bar_q       <= 3'd0;
      sub_q       <= {SUB_W{1'b0}};
      mode_q      <= 2'd0;
      level_q     <= 10'd0;
      frame_cnt_q <= 16'd0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      bar_q       <= bar_d;
      sub_q       <= sub_d;
      mode_q      <= mode_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      vs_q        <= vs_d;
      hs_q        <= hs_d;
      busy_q      <= busy_d;
    end
  end

  // Fed with next-cycle coordinates so its registered output matches hs_q.
  d8m_pattern_gen #(
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_gen (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .valid_i (hs_d),
    .x_i     (hcnt_d[9:0]),
    .y_lsb_i (vcnt_d[0]),
    .y_chk_i (vcnt_d[CHECK_LOG2]),
    .bar_i   (bar_d),
    .mode_i  (mode_d),
    .level_i (level_d),
    .pix_o   (pix_s)
  );

  assign bus.oPIXEL_VS  = vs_q;
  assign bus.oPIXEL_HS  = hs_q;
  assign bus.oPIXEL_D   = pix_s;
  assign bus.oFRAME_CNT = frame_cnt_q;
  assign bus.oBUSY      = busy_q;

endmodule

// File: tb/tb_d8m_pattern_tx.sv
// tb_d8m_pattern_tx: directed bench for d8m_pattern_tx with a small frame
// (16x4 active, 4-clock line blank, 10-clock frame blank, 2-pixel checker).
module tb_d8m_pattern_tx;
  import d8m_tx_pkg::*;

  localparam int HA = 16;
  localparam int HB = 4;
  localparam int VA = 4;
  localparam int VB = 10;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  d8m_pattern_tx_if bus();

  d8m_pattern_tx #(
    .H_ACTIVE     (HA),
    .H_BLANK      (HB),
    .V_ACTIVE     (VA),
    .V_BLANK_CLKS (VB),
    .CHECK_LOG2   (1)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- bus monitor (samples on falling edge) ----------------
  int         cyc = 0;
  logic       vs_prev = 1'b0, hs_prev = 1'b0;
  int         mx = 0, my = 0;
  logic [9:0] cap [VA][HA];
  int         hs_pulses = 0, bad_len = 0, d_viol = 0, vs_rises = 0;
  int         last_rise = 0, prev_rise = 0, vs_fall_cyc = 0, last_pix_cyc = 0;

  always @(posedge iCLK) cyc++;

  always @(negedge iCLK) begin
    if (bus.oPIXEL_VS && !vs_prev) begin
      vs_rises++;
      prev_rise = last_rise;
      last_rise = cyc;
      my = 0;
      mx = 0;
      hs_pulses = 0;
    end
    if (!bus.oPIXEL_VS && vs_prev) vs_fall_cyc = cyc;
    if (bus.oPIXEL_HS) begin
      if (my < VA && mx < HA) cap[my][mx] = bus.oPIXEL_D;
      mx++;
      last_pix_cyc = cyc;
    end else begin
      if (hs_prev) begin
        hs_pulses++;
        if (mx != HA) bad_len++;
        my++;
        mx = 0;
      end
      if (bus.oPIXEL_D !== 10'd0) d_viol++;
    end
    vs_prev = bus.oPIXEL_VS;
    hs_prev = bus.oPIXEL_HS;
  end

  // Wait (bounded) for VS or HS to reach lvl; n = falling edges waited.
  task automatic wait_sig(input string tag, input bit use_hs, input logic lvl,
                          input int max, output int n);
    logic v;
    n = 0;
    v = ~lvl;
    while (n < max) begin
      @(negedge iCLK);
      #1;
      n++;
      v = use_hs ? bus.oPIXEL_HS : bus.oPIXEL_VS;
      if (v === lvl) break;
    end
    if (v !== lvl) check_eq({tag, "_timeout"}, {31'd0, v}, {31'd0, lvl});
  endtask

  int c, errs, rises_snap;

  initial begin
    bus.iEN    = 1'b1;
    bus.iMODE  = 2'd0;
    bus.iLEVEL = 10'd0;
    repeat (3) @(negedge iCLK);
    #1;
    check_eq("rst_vs",    {31'd0, bus.oPIXEL_VS}, 32'd0);
    check_eq("rst_hs",    {31'd0, bus.oPIXEL_HS}, 32'd0);
    check_eq("rst_d",     {22'd0, bus.oPIXEL_D}, 32'd0);
    check_eq("rst_fcnt",  {16'd0, bus.oFRAME_CNT}, 32'd0);
    check_eq("rst_busy",  {31'd0, bus.oBUSY}, 32'd0);

    // ---- Test 1/2: timing and colour bars ----
    iRST = 1'b0;
    wait_sig("vs_rise1", 1'b0, 1'b1, 50, c);
    check_eq("vs_rise_delay", c, 11);
    check_eq("busy_frame", {31'd0, bus.oBUSY}, 32'd1);
    wait_sig("hs_rise1", 1'b1, 1'b1, 50, c);
    check_eq("vs_to_hs", c, 4);
    wait_sig("vs_fall1", 1'b0, 1'b0, 200, c);
    check_eq("hs_pulses", hs_pulses, 4);
    check_eq("hs_len_bad", bad_len, 0);
    check_eq("vs_fall_after_pix", vs_fall_cyc - last_pix_cyc, 1);
    check_eq("fcnt_1", {16'd0, bus.oFRAME_CNT}, 32'd1);
    check_eq("bars_y0_x0",  {22'd0, cap[0][0]},  32'd1023);
    check_eq("bars_y0_x1",  {22'd0, cap[0][1]},  32'd1023);
    check_eq("bars_y0_x11", {22'd0, cap[0][11]}, 32'd1023);
    check_eq("bars_y0_x12", {22'd0, cap[0][12]}, 32'd0);
    check_eq("bars_y0_x13", {22'd0, cap[0][13]}, 32'd0);
    check_eq("bars_y1_x12", {22'd0, cap[1][12]}, 32'd1023);
    check_eq("bars_y1_x6",  {22'd0, cap[1][6]},  32'd0);
    errs = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 14; x < HA; x++)
        if (cap[y][x] !== 10'd0) errs++;
    check_eq("bars_black", errs, 0);

    // ---- checkerboard frame, and frame period ----
    bus.iMODE = 2'd2;
    wait_sig("vs_rise2", 1'b0, 1'b1, 50, c);
    check_eq("vs_low_gap", c, 10);
    check_eq("frame_period", last_rise - prev_rise, 90);
    wait_sig("vs_fall2", 1'b0, 1'b0, 200, c);
    check_eq("chk_y0_x0", {22'd0, cap[0][0]}, 32'd0);
    check_eq("chk_y0_x2", {22'd0, cap[0][2]}, 32'd1023);
    check_eq("chk_y2_x0", {22'd0, cap[2][0]}, 32'd1023);
    check_eq("chk_y3_x3", {22'd0, cap[3][3]}, 32'd0);

    // ---- Test 3: flat, with a mid-frame mode change ----
    bus.iMODE  = 2'd3;
    bus.iLEVEL = 10'h155;
    wait_sig("vs_rise3", 1'b0, 1'b1, 50, c);
    wait_sig("hs3a", 1'b1, 1'b1, 50, c);
    wait_sig("hs3b", 1'b1, 1'b0, 50, c);
    wait_sig("hs3c", 1'b1, 1'b1, 50, c);
    bus.iMODE  = 2'd1;
    bus.iLEVEL = 10'h2AA;
    wait_sig("vs_fall3", 1'b0, 1'b0, 200, c);
    errs = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (cap[y][x] !== 10'h155) errs++;
    check_eq("flat_no_tear", errs, 0);
    check_eq("flat_y3_x15", {22'd0, cap[3][15]}, 32'h155);
    wait_sig("vs_rise4", 1'b0, 1'b1, 50, c);
    wait_sig("vs_fall4", 1'b0, 1'b0, 200, c);
    for (int x = 0; x < HA; x++) check_eq("ramp_y0", {22'd0, cap[0][x]}, x);
    check_eq("ramp_y2_x15", {22'd0, cap[2][15]}, 32'd15);

    // ---- Test 4: drop iEN during line 2 ----
    wait_sig("vs_rise5", 1'b0, 1'b1, 50, c);
    wait_sig("hs5a", 1'b1, 1'b1, 50, c);
    wait_sig("hs5b", 1'b1, 1'b0, 50, c);
    wait_sig("hs5c", 1'b1, 1'b1, 50, c);
    wait_sig("hs5d", 1'b1, 1'b0, 50, c);
    wait_sig("hs5e", 1'b1, 1'b1, 50, c);
    bus.iEN = 1'b0;
    wait_sig("vs_fall5", 1'b0, 1'b0, 200, c);
    check_eq("noen_lines", hs_pulses, 4);
    check_eq("noen_len_bad", bad_len, 0);
    check_eq("fcnt_5", {16'd0, bus.oFRAME_CNT}, 32'd5);
    rises_snap = vs_rises;
    repeat (120) @(negedge iCLK);
    #1;
    check_eq("idle_busy", {31'd0, bus.oBUSY}, 32'd0);
    check_eq("idle_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    check_eq("idle_no_vs", vs_rises, rises_snap);

    // ---- Test 5: asynchronous reset mid-line ----
    bus.iEN = 1'b1;
    wait_sig("vs_rise6", 1'b0, 1'b1, 50, c);
    check_eq("en_to_vs", c, 11);
    wait_sig("hs6", 1'b1, 1'b1, 50, c);
    repeat (3) @(negedge iCLK);
    #1;
    check_eq("pre_rst_d", {22'd0, bus.oPIXEL_D}, 32'd3);
    iRST = 1'b1;
    #1;
    check_eq("arst_vs", {31'd0, bus.oPIXEL_VS}, 32'd0);
    check_eq("arst_hs", {31'd0, bus.oPIXEL_HS}, 32'd0);
    check_eq("arst_d",  {22'd0, bus.oPIXEL_D}, 32'd0);
    check_eq("arst_fcnt", {16'd0, bus.oFRAME_CNT}, 32'd0);
    repeat (2) @(negedge iCLK);
    #1;
    iRST = 1'b0;
    wait_sig("vs_rise7", 1'b0, 1'b1, 50, c);
    check_eq("rst_gap", c, 11);

    // ---- Test 6: frame counter wrap ----
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge iCLK);
    #1;
    release dut.frame_cnt_q;
    @(negedge iCLK);
    #1;
    check_eq("fcnt_preload", {16'd0, bus.oFRAME_CNT}, 32'hFFFF);
    wait_sig("vs_fall7", 1'b0, 1'b0, 200, c);
    check_eq("fcnt_wrap", {16'd0, bus.oFRAME_CNT}, 32'd0);

    check_eq("d_outside_hs", d_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
